// File: rtl/dark_min_filter_3x3.sv
// 3x3 trailing-window minimum (erosion) of the dark channel, one pixel per clock via two line buffers.
// Fixed 3-cycle latency for data, de and syncs; no backpressure, the stream is accepted every cycle.
module dark_min_filter_3x3 #(
  parameter int MAX_WIDTH = 1920,
  parameter int CNT_W     = 11
) (
  input  logic       pixelclk,
  input  logic       reset_n,
  input  logic [7:0] i_dark,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic       i_de,
  output logic [7:0] o_dark_min,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_de
);

  localparam int                 AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [CNT_W-1:0]   MAXW = CNT_W'(MAX_WIDTH);
  localparam logic [7:0]         PAD  = 8'hFF;

  function automatic logic [7:0] min2(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [CNT_W-1:0] col;
  logic [1:0]       row;
  logic [AW-1:0]    addr;
  logic             col_ok;

  logic [7:0] lb0 [MAX_WIDTH];
  logic [7:0] lb1 [MAX_WIDTH];
  logic [7:0] lb0_rd, lb1_rd;
  logic [7:0] t0, t1, t2;

  // stage 1
  logic [7:0] colmin_s1;
  logic       vld_s1, ge1_s1, ge2_s1;
  logic       de_s1, hs_s1, vs_s1;

  // stage 2
  logic [7:0] cm0, cm1, cm2;
  logic       de_s2, hs_s2, vs_s2;

  assign col_ok = (col < MAXW);
  assign addr   = col[AW-1:0];
  assign lb0_rd = lb0[addr];
  assign lb1_rd = lb1[addr];

  // Out-of-frame taps read as 0xFF so they never win the minimum.
  assign t0 = col_ok ? i_dark : PAD;
  assign t1 = (col_ok && row != 2'd0) ? lb0_rd : PAD;
  assign t2 = (col_ok && row == 2'd2) ? lb1_rd : PAD;

  // Line-buffer RAM is deliberately not reset; stale rows are masked by row.
  always_ff @(posedge pixelclk) begin
    if (reset_n && i_de && col_ok) begin
      lb0[addr] <= i_dark;
      lb1[addr] <= lb0_rd;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      col <= '0;
      row <= 2'd0;
    end else begin
      if (!i_de)
        col <= '0;
      else if (col < MAXW)
        col <= col + 1'b1;

      if (i_vsync)
        row <= 2'd0;
      else if (de_s1 && !i_de && row != 2'd2)
        row <= row + 2'd1;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      colmin_s1 <= 8'd0;
      vld_s1    <= 1'b0;
      ge1_s1    <= 1'b0;
      ge2_s1    <= 1'b0;
      de_s1     <= 1'b0;
      hs_s1     <= 1'b0;
      vs_s1     <= 1'b0;
    end else begin
      colmin_s1 <= min2(t0, min2(t1, t2));
      vld_s1    <= col_ok;
      ge1_s1    <= (col >= CNT_W'(1));
      ge2_s1    <= (col >= CNT_W'(2));
      de_s1     <= i_de;
      hs_s1     <= i_hsync;
      vs_s1     <= i_vsync;
    end
  end

  // The ge flags stop the column window carrying values over from the previous line.
  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      cm0   <= 8'd0;
      cm1   <= 8'd0;
      cm2   <= 8'd0;
      de_s2 <= 1'b0;
      hs_s2 <= 1'b0;
      vs_s2 <= 1'b0;
    end else begin
      cm0   <= vld_s1 ? colmin_s1 : PAD;
      cm1   <= (vld_s1 && ge1_s1) ? cm0 : PAD;
      cm2   <= (vld_s1 && ge2_s1) ? cm1 : PAD;
      de_s2 <= de_s1;
      hs_s2 <= hs_s1;
      vs_s2 <= vs_s1;
    end
  end

  always_ff @(posedge pixelclk) begin
    if (!reset_n) begin
      o_dark_min <= 8'd0;
      o_de       <= 1'b0;
      o_hsync    <= 1'b0;
      o_vsync    <= 1'b0;
    end else begin
      o_dark_min <= de_s2 ? min2(cm0, min2(cm1, cm2)) : 8'd0;
      o_de       <= de_s2;
      o_hsync    <= hs_s2;
      o_vsync    <= vs_s2;
    end
  end

endmodule
